// File: rtl/split_pair_using_fifos_pkg.sv
// Shared types and helpers for the pair fork: one {a,b} stream split into two FIFO'd streams.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package split_pair_using_fifos_pkg;

  localparam int default_width = 8;
  localparam int default_depth = 10;

  // Occupancy counter holds 0..depth inclusive; pointers address 0..depth-1.
  localparam int count_w = $clog2(default_depth + 1);
  localparam int ptr_w   = $clog2(default_depth);

  // Field order matches the in_data layout: a in the upper half, b in the lower half.
  typedef struct packed {
    logic [default_width-1:0] a;
    logic [default_width-1:0] b;
  } pair_t;

  // Pointer advance with explicit wrap so non-power-of-two depths go depth-1 -> 0.
  function automatic int next_ptr(input int p, input int d);
    return (p == d - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/ff_fifo_arst.sv
// Flip-flop FIFO with occupancy count, depth need not be a power of two.
// Latency: a push is visible at read_data/~empty on the next clock edge, no fall-through.
// Backpressure: push ignored while full, pop ignored while empty; full/empty are registered state only.
module ff_fifo_arst
  import split_pair_using_fifos_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  logic [width-1:0] r_mem [depth];
  logic [pw-1:0]    r_wr_ptr;
  logic [pw-1:0]    r_rd_ptr;
  logic [cw-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == cw'(depth));
  assign count     = r_count;
  assign read_data = r_mem[r_rd_ptr];

  // Guard the strobes so a misbehaving caller can never corrupt the count.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= pw'(next_ptr(int'(r_wr_ptr), depth));
      end
      if (w_pop) begin
        r_rd_ptr <= pw'(next_ptr(int'(r_rd_ptr), depth));
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/split_pair_using_fifos.sv
// Fork of a packed {a,b} pair stream into two independently drained valid/ready streams.
// Latency: one clock from accepted pair to both output heads; no combinational data path.
// Backpressure: in_ready drops when either branch FIFO is full, so pairs are never split.
module split_pair_using_fifos
  import split_pair_using_fifos_pkg::*;
#(
  parameter int width = default_width,
  parameter int depth = default_depth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*width-1:0]         in_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [width-1:0]           a_data,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [width-1:0]           b_data,
  output logic [$clog2(depth+1)-1:0] a_count,
  output logic [$clog2(depth+1)-1:0] b_count
);

  typedef struct packed {
    logic [width-1:0] a;
    logic [width-1:0] b;
  } fork_pair_t;

  fork_pair_t w_in;
  logic       w_push;
  logic       w_a_full;
  logic       w_b_full;
  logic       w_a_empty;
  logic       w_b_empty;

  assign w_in = in_data;

  // Accept only when both branches have room; depends on FIFO state, never on in_valid.
  assign in_ready = ~w_a_full & ~w_b_full;
  assign w_push   = in_valid & in_ready;
  assign a_valid  = ~w_a_empty;
  assign b_valid  = ~w_b_empty;

  ff_fifo_arst #(.width(width), .depth(depth)) u_a_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .pop        (a_valid & a_ready),
    .write_data (w_in.a),
    .read_data  (a_data),
    .empty      (w_a_empty),
    .full       (w_a_full),
    .count      (a_count)
  );

  ff_fifo_arst #(.width(width), .depth(depth)) u_b_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .pop        (b_valid & b_ready),
    .write_data (w_in.b),
    .read_data  (b_data),
    .empty      (w_b_empty),
    .full       (w_b_full),
    .count      (b_count)
  );

endmodule

// File: tb/tb_split_pair_using_fifos.sv
// Bench for the pair fork: queue-based reference model, per-cycle compare, directed and random phases.
// Latency: model mirrors the one-clock push-to-head behaviour using plain queues.
// Backpressure: model accepts a pair only when both queues hold fewer than depth entries.
module tb_split_pair_using_fifos;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] in_data;
  logic          a_valid;
  logic          a_ready;
  logic [W-1:0]  a_data;
  logic          b_valid;
  logic          b_ready;
  logic [W-1:0]  b_data;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  split_pair_using_fifos #(.width(W), .depth(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two queues, a pair goes into both when both have room.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      logic acc;
      logic pa;
      logic pb;
      acc = in_valid && (qa.size() < D) && (qb.size() < D);
      pa  = a_ready && (qa.size() > 0);
      pb  = b_ready && (qb.size() > 0);
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
        qa.push_back(in_data[2*W-1:W]);
        qb.push_back(in_data[W-1:0]);
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, (qa.size() < D && qb.size() < D));
      chk("a_valid", a_valid, qa.size() != 0);
      chk("b_valid", b_valid, qb.size() != 0);
      chk("a_count", a_count, qa.size());
      chk("b_count", b_count, qb.size());
      if (qa.size() != 0) chk("a_data", a_data, qa[0]);
      if (qb.size() != 0) chk("b_data", b_data, qb[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input int n, input logic [W-1:0] a0, input logic [W-1:0] b0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = {a0 + W'(i), b0 + W'(i)};
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_a_valid", a_valid, 0);
    chk("reset_b_count", b_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single pair
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3C05;
    tick();
    in_valid = 1'b0;
    chk("single_a_valid", a_valid, 1);
    chk("single_a_data", a_data, 8'h3C);
    chk("single_b_data", b_data, 8'h05);
    tick();
    chk("single_a_drained", a_valid, 0);
    chk("single_b_drained", b_valid, 0);
    chk("single_b_count", b_count, 0);

    // Independent drain: a flows, b stalls
    b_ready = 1'b0;
    push_pairs(3, 8'h01, 8'h11);
    chk("drain_a_head", a_data, 8'h03);
    chk("drain_b_count", b_count, 3);
    b_ready = 1'b1;
    tick();
    chk("drain_b_next", b_data, 8'h12);
    tick();
    tick();
    chk("drain_b_empty", b_valid, 0);

    // Backpressure from the b branch alone
    b_ready = 1'b0;
    push_pairs(4, 8'h21, 8'h31);
    chk("bp_b_count", b_count, 4);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 16'h2535;
    tick();
    chk("bp_held", b_count, 4);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("bp_after_pop_count", b_count, 3);
    chk("bp_after_pop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_fifth_accepted", b_count, 4);
    b_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Full on both branches with same-cycle pop: no bypass
    a_ready = 1'b0;
    b_ready = 1'b0;
    push_pairs(4, 8'h41, 8'h51);
    in_valid = 1'b1;
    in_data  = 16'h4555;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    chk("full_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk("full_pop_a_count", a_count, 3);
    chk("full_pop_b_count", b_count, 3);
    chk("full_pop_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) tick();

    // Random streaming with independent consumers; pointers wrap many times
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom);
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset mid-operation with counts 2/3
    a_ready = 1'b0;
    b_ready = 1'b0;
    push_pairs(3, 8'h61, 8'h71);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("pre_rst_a_count", a_count, 2);
    chk("pre_rst_b_count", b_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_a_valid", a_valid, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_a_count", a_count, 0);
    chk("arst_b_count", b_count, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hAA55;
    tick();
    in_valid = 1'b0;
    chk("post_rst_a_data", a_data, 8'hAA);
    chk("post_rst_b_data", b_data, 8'h55);
    chk("post_rst_b_valid", b_valid, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_pair_using_fifos.md
Name: split_pair_using_fifos

Overview:
- Fork counterpart of the two-stream adder join: one valid/ready input stream carries packed operand pairs {a, b}.
- The block splits each pair into two independent valid/ready output streams, a and b.
- Each branch has its own flip-flop FIFO, so one consumer may stall while the other drains.
- Sits upstream of any block that consumes operands on separate handshakes, e.g. a test source feeding the two-input adder.

Parameters:
- width, 8, bits per operand; in_data is 2*width.
- depth, 10, entries per branch FIFO; legal range >= 2; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_data  input  2*width  pair; [2*width-1:width] = a, [width-1:0] = b.
- a_valid  output  1  a branch head valid.
- a_ready  input  1  a consumer ready.
- a_data  output  width  a branch head.
- b_valid  output  1  b branch head valid.
- b_ready  input  1  b consumer ready.
- b_data  output  width  b branch head.
- a_count  output  $clog2(depth+1)  a FIFO occupancy.
- b_count  output  $clog2(depth+1)  b FIFO occupancy.

Behaviour:
- Reset, asynchronous and active-high:
  - Clears all pointers and counters.
  - a_valid=0, b_valid=0, a_count=0, b_count=0, in_ready=1.
  - Storage is not reset.
  - a_data/b_data are don't-care while the matching valid is 0.
- Input handshake:
  - in_ready = ~a_full & ~b_full.
  - Accept when in_valid & in_ready; both FIFOs push in the same cycle. A pair is never split across cycles.
  - in_ready is combinational from FIFO state only, never from in_valid.
- Output handshake:
  - a_valid = ~a_empty; a_data = a FIFO head. b is identical.
  - Pop on a_valid & a_ready, independent of b.
  - Once a valid is high it stays high with stable data until the transfer completes.
- Latency:
  - An accepted pair is visible at both outputs on the next clock edge.
  - No combinational fall-through from in_data to a_data/b_data.
- Counters:
  - count +1 on push only, -1 on pop only, unchanged on push & pop.
  - full = (count == depth); empty = (count == 0).
- Pointers:
  - Write and read pointers wrap from depth-1 to 0.
  - Non-power-of-two depth must wrap correctly; e.g. depth=10 goes 9 -> 0.
- Boundary conditions:
  - One branch full, other empty: in_ready=0; the empty branch keeps draining; no pair is accepted.
  - Full branch with same-cycle pop: in_ready is still 0 that cycle (no bypass). It goes to 1 the cycle after the pop.
  - Empty branch with same-cycle push: no pop; valid rises next cycle.
  - Push & pop on a non-empty, non-full branch: count unchanged; order preserved.
  - Occupancy skew: |a_count - b_count| never exceeds depth.
  - Reset mid-operation: all queued pairs are discarded immediately; no output handshake completes in the reset cycle.
- Ordering: each branch is strictly FIFO, and the a and b sequences keep pair order.

Decomposition:
- Shared package:
  - Localparam count_w = $clog2(depth+1) and ptr_w = $clog2(depth).
  - Typedef pair_t as a packed struct {a, b} of width-bit fields, matching the in_data layout.
- Sub-module ff_fifo_arst:
  - Parameters width and depth.
  - Ports push, pop, write_data, read_data, empty, full, count.
  - Asynchronous active-high reset.
  - Instantiated twice, once per branch.
- The top contains only the fork logic.

Test Plan (width=8, depth=4):
- Single pair: in_data=16'h3C05 accepted at cycle 0, a_ready=b_ready=1 -> cycle 1 a_valid=b_valid=1, a_data=8'h3C, b_data=8'h05; cycle 2 both valid=0, counts=0.
- Independent drain: push pairs {01,11},{02,12},{03,13} with b_ready=0, a_ready=1 -> a outputs 01,02,03 on consecutive cycles; b_count=3; b_ready=1 then b outputs 11,12,13.
- Backpressure: b_ready=0, push 4 pairs -> b_count=4, in_ready=0, 5th pair held. Pop one b -> in_ready=1 the following cycle; 5th pair accepted; a sees 5 values in order.
- Wrap-around: stream 12 pairs with random a_ready/b_ready (seeded) -> both sequences match a scoreboard; pointers pass 3 -> 0 at least twice; no loss or duplication.
- Full with same-cycle pop: both FIFOs full (count=4), a_ready=b_ready=1, in_valid=1 -> in_ready=0 that cycle, counts become 3, in_ready=1 next cycle.
- Async reset: with counts 2/3, assert rst between clock edges -> a_valid=b_valid=0 and counts=0 immediately, in_ready=1. After deassert, pair 16'hAA55 yields a_data=AA, b_data=55 one cycle later.
